// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, totals helpers and sync-polarity constants for the VGA path.
package vga_timing_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_WIN_X0   = 192;
    localparam int unsigned DEF_WIN_Y0   = 112;
    localparam int unsigned DEF_WIN_W    = 256;
    localparam int unsigned DEF_WIN_H    = 256;
    localparam int unsigned DEF_CW       = 10;
    localparam int unsigned DEF_FW       = 8;

    // Level a sync pin takes while the pulse is asserted
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Pixels per line including blanking
    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking
    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter that wraps to 0 after LAST; wrap_c flags the wrapping tick.
module vga_wrap_counter #(
    parameter int unsigned CW   = 10,
    parameter int unsigned LAST = 799
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next_c,
    output logic          wrap_c
);

    localparam logic [CW-1:0] LAST_V = CW'(LAST);

    // Next count and wrap detect
    always_comb begin
        wrap_c       = en && (count == LAST_V);
        count_next_c = count;
        if (en) begin
            count_next_c = (count == LAST_V) ? '0 : count + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else begin
            count <= count_next_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-window masking.
// Define VGA_TIMING_WINDOW_EN to enable window masking/coordinates; without it the
// window is the whole active area and the WIN_* parameters have no effect.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        H_POL    = SYNC_ACTIVE_LOW,
    parameter logic        V_POL    = SYNC_ACTIVE_LOW,
    parameter int unsigned WIN_X0   = DEF_WIN_X0,
    parameter int unsigned WIN_Y0   = DEF_WIN_Y0,
    parameter int unsigned WIN_W    = DEF_WIN_W,
    parameter int unsigned WIN_H    = DEF_WIN_H,
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned FW       = DEF_FW
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          Enable,
    input  logic [2:0]    iRGB,
    output logic [CW-1:0] oHcounter,
    output logic [CW-1:0] oVcounter,
    output logic [CW-1:0] oWinX,
    output logic [CW-1:0] oWinY,
    output logic          oInWindow,
    output logic          oHsync,
    output logic          oVsync,
    output logic          oActive,
    output logic [2:0]    oRGB,
    output logic          oLineStart,
    output logic          oFrameStart,
    output logic [FW-1:0] oFrameCount
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TIMING_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    localparam logic [CW-1:0] WX_BEG = CW'(WIN_X0);
    localparam logic [CW-1:0] WX_END = CW'(WIN_X0 + WIN_W);
    localparam logic [CW-1:0] WY_BEG = CW'(WIN_Y0);
    localparam logic [CW-1:0] WY_END = CW'(WIN_Y0 + WIN_H);
    // Coordinates are window-relative only when masking is on
    localparam logic [CW-1:0] X_OFS  = WINDOW_EN ? WX_BEG : '0;
    localparam logic [CW-1:0] Y_OFS  = WINDOW_EN ? WY_BEG : '0;

    logic [CW-1:0] h_count, v_count, h_next_c, v_next_c;
    logic          h_wrap_c, v_wrap_c, v_en_c;
    logic          next_act_c, next_win_c, next_in_win_c, cur_act_c, pix_ok_c;
    logic [CW-1:0] win_x, win_y;
    logic          in_win, hsync, vsync, active, line_start, frame_start;
    logic [2:0]    rgb;
    logic [FW-1:0] frame_count;

    assign v_en_c = Enable & h_wrap_c;

    vga_wrap_counter #(.CW(CW), .LAST(H_TOTAL - 1)) u_hcnt (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .en           (Enable),
        .count        (h_count),
        .count_next_c (h_next_c),
        .wrap_c       (h_wrap_c)
    );

    vga_wrap_counter #(.CW(CW), .LAST(V_TOTAL - 1)) u_vcnt (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .en           (v_en_c),
        .count        (v_count),
        .count_next_c (v_next_c),
        .wrap_c       (v_wrap_c)
    );

    // Window/active decode for the upcoming and the current address position
    always_comb begin
        next_act_c    = (h_next_c < H_ACT_END) && (v_next_c < V_ACT_END);
        next_win_c    = (h_next_c >= WX_BEG) && (h_next_c < WX_END) &&
                        (v_next_c >= WY_BEG) && (v_next_c < WY_END);
        next_in_win_c = WINDOW_EN ? next_win_c : next_act_c;
        cur_act_c     = (h_count < H_ACT_END) && (v_count < V_ACT_END);
        pix_ok_c      = WINDOW_EN ? (cur_act_c && in_win) : cur_act_c;
    end

    // Address-phase window flag and coordinates, aligned with the counters
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            in_win <= 1'b0;
            win_x  <= '0;
            win_y  <= '0;
        end else if (Enable) begin
            in_win <= next_in_win_c;
            win_x  <= next_in_win_c ? h_next_c - X_OFS : '0;
            win_y  <= next_in_win_c ? v_next_c - Y_OFS : '0;
        end
    end

    // Display phase: one Enable tick behind the address phase
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hsync  <= ~H_POL;
            vsync  <= ~V_POL;
            active <= 1'b0;
            rgb    <= '0;
        end else if (Enable) begin
            hsync  <= ((h_count >= HS_BEG) && (h_count < HS_END)) ? H_POL : ~H_POL;
            vsync  <= ((v_count >= VS_BEG) && (v_count < VS_END)) ? V_POL : ~V_POL;
            active <= cur_act_c;
            rgb    <= pix_ok_c ? iRGB : '0;
        end
    end

    // Line/frame strobes and completed-frame count
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= h_wrap_c;
            frame_start <= v_wrap_c;
            if (v_wrap_c) begin
                frame_count <= frame_count + FW'(1);
            end
        end
    end

    assign oHcounter   = h_count;
    assign oVcounter   = v_count;
    assign oWinX       = win_x;
    assign oWinY       = win_y;
    assign oInWindow   = in_win;
    assign oHsync      = hsync;
    assign oVsync      = vsync;
    assign oActive     = active;
    assign oRGB        = rgb;
    assign oLineStart  = line_start;
    assign oFrameStart = frame_start;
    assign oFrameCount = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 16x12 raster; works with or without VGA_TIMING_WINDOW_EN.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned HA = 10, HF = 2, HS = 3, HB = 1;
    localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int unsigned WX = 3,  WY = 2, WW = 4, WH = 5;
    localparam int unsigned CWB = 5, FWB = 6;
    localparam logic        HPOL = SYNC_ACTIVE_LOW;
    localparam logic        VPOL = SYNC_ACTIVE_HIGH;
    localparam int unsigned HT = HA + HF + HS + HB;   // 16
    localparam int unsigned VT = VA + VF + VS + VB;   // 12
    localparam int unsigned FT = HT * VT;             // 192
    localparam int unsigned FMOD = 1 << FWB;          // 64
`ifdef VGA_TIMING_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic            Clock = 1'b0, Reset_n = 1'b0, Enable = 1'b0;
    logic [2:0]      iRGB = 3'd0;
    logic [CWB-1:0]  oHcounter, oVcounter, oWinX, oWinY;
    logic            oInWindow, oHsync, oVsync, oActive, oLineStart, oFrameStart;
    logic [2:0]      oRGB;
    logic [FWB-1:0]  oFrameCount;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(HPOL), .V_POL(VPOL),
        .WIN_X0(WX), .WIN_Y0(WY), .WIN_W(WW), .WIN_H(WH),
        .CW(CWB), .FW(FWB)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .iRGB(iRGB),
        .oHcounter(oHcounter), .oVcounter(oVcounter), .oWinX(oWinX), .oWinY(oWinY),
        .oInWindow(oInWindow), .oHsync(oHsync), .oVsync(oVsync), .oActive(oActive),
        .oRGB(oRGB), .oLineStart(oLineStart), .oFrameStart(oFrameStart),
        .oFrameCount(oFrameCount)
    );

    initial forever #5 Clock = ~Clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything follows from t, the number of Enable ticks since reset
    int unsigned t = 0;
    logic        m_hs = ~HPOL, m_vs = ~VPOL, m_act = 1'b0, m_ls = 1'b0, m_fs = 1'b0;
    logic [2:0]  m_rgb = 3'd0;

    function automatic int unsigned hpos(input int unsigned tt);
        return tt % HT;
    endfunction
    function automatic int unsigned vpos(input int unsigned tt);
        return (tt / HT) % VT;
    endfunction
    function automatic bit act_at(input int unsigned h, input int unsigned v);
        return (h < HA) && (v < VA);
    endfunction
    function automatic bit win_at(input int unsigned h, input int unsigned v);
        if (WIN) return (h >= WX) && (h < WX + WW) && (v >= WY) && (v < WY + WH);
        return act_at(h, v);
    endfunction
    // Window flag as driven on oInWindow (cleared by reset before the first tick)
    function automatic bit inwin_out(input int unsigned tt);
        return (tt != 0) && win_at(hpos(tt), vpos(tt));
    endfunction
    function automatic int unsigned winx_out(input int unsigned tt);
        return inwin_out(tt) ? hpos(tt) - (WIN ? WX : 0) : 0;
    endfunction
    function automatic int unsigned winy_out(input int unsigned tt);
        return inwin_out(tt) ? vpos(tt) - (WIN ? WY : 0) : 0;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            t = 0; m_hs = ~HPOL; m_vs = ~VPOL; m_act = 1'b0; m_rgb = 3'd0;
            m_ls = 1'b0; m_fs = 1'b0;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
            if (Enable) begin
                m_hs  = (hpos(t) >= HA + HF && hpos(t) < HA + HF + HS) ? HPOL : ~HPOL;
                m_vs  = (vpos(t) >= VA + VF && vpos(t) < VA + VF + VS) ? VPOL : ~VPOL;
                m_act = act_at(hpos(t), vpos(t));
                if (WIN) m_rgb = (act_at(hpos(t), vpos(t)) && inwin_out(t)) ? iRGB : 3'd0;
                else     m_rgb = act_at(hpos(t), vpos(t)) ? iRGB : 3'd0;
                t++;
                m_ls = (hpos(t) == 0);
                m_fs = (t % FT) == 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge Clock) begin
        if (cmp_on) begin
            chk("hcount",  oHcounter,   hpos(t));
            chk("vcount",  oVcounter,   vpos(t));
            chk("inwin",   oInWindow,   inwin_out(t));
            chk("winx",    oWinX,       winx_out(t));
            chk("winy",    oWinY,       winy_out(t));
            chk("frames",  oFrameCount, (t / FT) % FMOD);
            chk("hsync",   oHsync,      m_hs);
            chk("vsync",   oVsync,      m_vs);
            chk("active",  oActive,     m_act);
            chk("rgb",     oRGB,        m_rgb);
            chk("lstart",  oLineStart,  m_ls);
            chk("fstart",  oFrameStart, m_fs);
        end
    end

    task automatic step(input logic en, input logic [2:0] rgb);
        Enable = en;
        iRGB   = rgb;
        @(posedge Clock);
        #1;
    endtask

    int n_hs, n_ls, n_vs, n_fs, n_px;
    int winx_a, winx_b;

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        cmp_on  = 1'b1;

        // Mid-frame reset: 100 ticks -> H=4, V=6
        repeat (100) step(1'b1, 3'($urandom_range(7, 0)));
        chk("pre_reset_h", oHcounter, 4);
        chk("pre_reset_v", oVcounter, 6);
        Reset_n = 1'b0;
        #1;
        chk("rst_h", oHcounter, 0);
        chk("rst_v", oVcounter, 0);
        chk("rst_hsync", oHsync, 1);
        chk("rst_vsync", oVsync, 0);
        chk("rst_active", oActive, 0);
        chk("rst_rgb", oRGB, 0);
        chk("rst_inwin", oInWindow, 0);
        chk("rst_winx", oWinX, 0);
        chk("rst_lstart", oLineStart, 0);
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        Reset_n = 1'b1;
        step(1'b1, 3'($urandom_range(7, 0)));
        chk("first_tick_h", oHcounter, 1);
        chk("first_tick_v", oVcounter, 0);

        // One full line with Enable high
        n_hs = 0; n_ls = 0;
        for (int i = 0; i < int'(HT); i++) begin
            step(1'b1, 3'($urandom_range(7, 0)));
            if (oHsync == HPOL) n_hs++;
            if (oLineStart) n_ls++;
        end
        chk("line_hsync_ticks", n_hs, 3);
        chk("line_start_pulses", n_ls, 1);

        // One full frame with a constant colour
        n_vs = 0; n_fs = 0; n_px = 0; winx_a = -1; winx_b = -1;
        for (int i = 0; i < int'(FT); i++) begin
            step(1'b1, 3'b101);
            if (oVsync == VPOL) n_vs++;
            if (oFrameStart) n_fs++;
            if (oRGB == 3'b101) n_px++;
            if (hpos(t) == 6 && vpos(t) == 3) winx_a = int'(oWinX);
            if (hpos(t) == 9 && vpos(t) == 3) winx_b = int'(oWinX);
        end
        chk("frame_vsync_ticks", n_vs, 32);
        chk("frame_start_pulses", n_fs, 1);
        chk("frame_lit_pixels", n_px, WIN ? 20 : 80);
        chk("frame_count_1", oFrameCount, 1);
        chk("winx_h6", winx_a, WIN ? 3 : 6);
        chk("winx_h9", winx_b, WIN ? 0 : 9);

        // Enable every other clock: two line starts, each one clock wide
        n_ls = 0;
        for (int i = 0; i < 4 * int'(HT); i++) begin
            step((i % 2) == 0, 3'($urandom_range(7, 0)));
            if (oLineStart) n_ls++;
        end
        chk("toggle_line_pulses", n_ls, 2);

        // Irregular Enable with random colours
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(2, 0) != 0, 3'($urandom_range(7, 0)));
        end

        // Run to the frame-counter wrap
        while (t < 64 * FT - 1) step(1'b1, 3'($urandom_range(7, 0)));
        chk("frames_before_wrap", oFrameCount, 63);
        step(1'b1, 3'($urandom_range(7, 0)));
        chk("frames_wrapped", oFrameCount, 0);
        chk("wrap_frame_start", oFrameStart, 1);
        step(1'b0, 3'd0);
        chk("strobe_low_idle", oFrameStart, 0);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel-window masker that replaces the fixed 640x480 controller in the display path. It produces horizontal and vertical counters, sync pulses, active-video and window flags, window-relative pixel coordinates, and line/frame strobes, all configurable in resolution, porches, sync polarity and window placement. It sits between the pixel clock-enable divider and the VGA pins. The pixel source (frame buffer or pattern logic) is addressed through the window coordinates.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- `H_POL`, `V_POL`, 0 / 0, sync active level (0 = active-low)
- `WIN_X0`, `WIN_Y0`, 192 / 112, window origin in active coordinates
- `WIN_W`, `WIN_H`, 256 / 256, window size
- `CW`, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- `FW`, 8, frame counter width
- `Clock`  in  1  system clock
- `Reset_n`  in  1  reset, asynchronous, active-low
- `Enable`  in  1  pixel tick; all state advances only when high
- `iRGB`  in  3  pixel colour from the source, for the current address phase
- `oHcounter`, `oVcounter`  out  CW  address-phase counters
- `oWinX`, `oWinY`  out  CW  window-relative coordinates; 0 outside the window
- `oInWindow`  out  1  address-phase pixel is inside the window
- `oHsync`, `oVsync`  out  1  display-phase syncs
- `oActive`  out  1  display-phase active video
- `oRGB`  out  3  display-phase colour
- `oLineStart`, `oFrameStart`  out  1  single-Clock strobes
- `oFrameCount`  out  FW  completed-frame count

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 by default).
  - V_TOTAL is defined the same way from the vertical parameters (525 by default).
- Horizontal counter:
  - Increments on each Enable.
  - At H_TOTAL-1 it wraps to 0 and the vertical counter increments.
- Vertical counter:
  - At V_TOTAL-1, on the horizontal wrap, it wraps to 0 and oFrameCount increments, wrapping modulo 2^FW.
- Address phase (counters, oWinX, oWinY, oInWindow):
  - oInWindow = (H in [WIN_X0, WIN_X0+WIN_W)) and (V in [WIN_Y0, WIN_Y0+WIN_H)).
  - oWinX = H-WIN_X0 and oWinY = V-WIN_Y0 when in the window, else 0.
- Display phase (syncs, oActive, oRGB):
  - Registered on each Enable from the address phase.
  - Hsync is at active level for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vsync uses the same rule on V.
  - oActive = (H < H_ACTIVE) and (V < V_ACTIVE).
  - oRGB = iRGB when the prior address phase was active and in the window, else 0.
- Strobes:
  - oLineStart goes high for exactly one Clock cycle after the Enable edge that loads H=0.
  - oFrameStart goes high for exactly one Clock cycle after the Enable edge that loads (0,0).
- Enable low: all outputs hold, and strobes are low.

## Timing
- Reset (Reset_n low, asynchronous, may occur mid-frame):
  - Counters, window coordinates, oFrameCount and oRGB clear to 0.
  - oInWindow, oActive and the strobes clear to 0.
  - Syncs go to their inactive level (~H_POL, ~V_POL).
  - The first Enable after release advances the counters to H=1, V=0.
- Latency: display-phase outputs lag the address phase by exactly 1 Enable tick. iRGB is sampled on the Enable edge that ends the address phase.
- Wrap and event ordering:
  - The H wrap and V increment happen on the same edge.
  - On the (799,524) tick, H, V and the frame count update together.
- The `Enable` duty cycle is arbitrary, including continuously high or irregular.

## Configuration
- `VGA_TIMING_WINDOW_EN`
  - Defined: window masking and coordinates as above.
  - Undefined:
    - oInWindow equals address-phase active.
    - oWinX and oWinY equal the H and V counters during active video and 0 otherwise.
    - oRGB is masked only by active video.
    - The WIN_* parameters are ignored.

## Structure
- Package `vga_timing_pkg`:
  - Default timing constants for 640x480@60.
  - H_TOTAL/V_TOTAL computing functions.
  - Sync-polarity constants.
- Sub-module `vga_wrap_counter`: a CW-bit counter with enable, terminal-value wrap and a wrap pulse output. Instantiate it twice, horizontal and vertical, with the vertical enable driven by `Enable` AND horizontal wrap.

## Test plan
- Reset low mid-frame at H=300, V=200 -> all outputs clear immediately; oHsync=oVsync=1. Release then one Enable -> H=1, V=0.
- Enable held high for one line -> oHsync is low exactly for display-phase H 656..751 (96 ticks), and oLineStart pulses once per 800 ticks.
- Run 525 lines -> oVsync low on lines 490..491 only; oFrameStart pulses once; oFrameCount 0->1. After 256 frames, oFrameCount wraps to 0.
- Window at defaults, iRGB=3'b101 constant:
  - oRGB=101 only for display-phase H 192..447 and V 112..367, else 0.
  - oWinX=0 at H=192 and 255 at H=447.
- Enable toggled every other Clock -> the counter sequence is identical to the always-high run, and the strobes are still one Clock wide.
- Build without `VGA_TIMING_WINDOW_EN` -> oRGB=iRGB across the full 640x480 active area, and oWinX=639 at H=639.
